l15_xdcr_arb: RTL and testbench
===============================

L15_XDCR_ARB -- requirements
Module: l15_xdcr_arb

Interface
REQ-001 Parameter NUM_CH, default 2: number of upstream transducer channels, range 2..8.
REQ-002 Parameter TID_W, default 1: L1.5 threadid width; NUM_CH SHALL be <= 2**TID_W, checked at elaboration.
REQ-003 Parameter REQ_W, default 180: opaque request payload width (rqtype, size, nc, address, data, amo_op).
REQ-004 Parameter RSP_W, default 300: opaque response payload width (four data words and flags).
REQ-005 Ports, in this order:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- ch_req_val  in  NUM_CH  per-channel request valid.
- ch_req_payload  in  NUM_CH*REQ_W  per-channel request; channel i at slice i.
- ch_req_ack  out  NUM_CH  per-channel accept pulse.
- xdcr_l15_val  out  1  request valid to L1.5.
- xdcr_l15_payload  out  REQ_W  registered request.
- xdcr_l15_threadid  out  TID_W  granted channel index.
- l15_xdcr_ack  in  1  L1.5 accept.
- l15_xdcr_val  in  1  response valid from L1.5.
- l15_xdcr_returntype  in  4  response type.
- l15_xdcr_threadid  in  TID_W  response thread.
- l15_xdcr_payload  in  RSP_W  response body.
- xdcr_l15_req_ack  out  1  response consumed pulse.
- ch_rsp_val  out  NUM_CH  per-channel response valid.
- ch_rsp_returntype  out  4  shared registered type.
- ch_rsp_payload  out  RSP_W  shared registered body.
- ch_rsp_ack  in  NUM_CH  per-channel response accept.
- outstanding  out  NUM_CH  per-channel in-flight flag.
- err_unexp_rsp  out  1  sticky protocol error.

Function
REQ-006 Request FSM states: REQ_IDLE, REQ_LOCK.
REQ-007 REQ_IDLE: eligible = ch_req_val & ~outstanding. If any channel is eligible, grant one round-robin, starting at rr_ptr. Capture its payload and index, and go to REQ_LOCK. xdcr_l15_val rises the next cycle (1-cycle latency).
REQ-008 REQ_LOCK: hold xdcr_l15_val, payload and threadid stable until l15_xdcr_ack.
REQ-009 In the ack cycle, ch_req_ack[owner] SHALL pulse combinationally. outstanding[owner] sets, rr_ptr becomes owner+1 (wrapping at NUM_CH to 0), and the FSM returns to REQ_IDLE. There is no back-to-back grant in the same cycle.
REQ-010 A channel dropping ch_req_val while locked SHALL NOT cancel the locked request.
REQ-011 Response FSM states: RSP_IDLE, RSP_DELIVER.
REQ-012 RSP_IDLE with l15_xdcr_val:
- xdcr_l15_req_ack pulses in the same cycle.
- Type and payload are registered.
- The pending mask is loaded, then RSP_DELIVER.
REQ-013 Pending mask:
- Broadcast (returntype == L15_RET_INVAL or L15_RET_INT): all ones.
- Otherwise: one-hot of threadid.
REQ-014 RSP_DELIVER:
- ch_rsp_val = pending.
- Each ch_rsp_ack clears its pending bit.
- When the mask reaches zero, return to RSP_IDLE. The next response is accepted no earlier than the following cycle (one bubble).
REQ-015 A unicast delivery ack SHALL clear outstanding[threadid]. Broadcasts SHALL NOT alter outstanding.
REQ-016 Unicast response with threadid >= NUM_CH: acked to L1.5, pending mask zero, dropped, err_unexp_rsp set.
REQ-017 Unicast response to a channel with outstanding clear: delivered normally, err_unexp_rsp set.
REQ-018 err_unexp_rsp SHALL stay set until reset.
REQ-019 The request and response FSMs SHALL operate independently and concurrently. A set of outstanding[i] (request ack) and a clear of outstanding[i] (response ack) in the same cycle SHALL resolve to set.

Reset
REQ-020 rst_n low SHALL asynchronously force:
- both FSMs to IDLE;
- rr_ptr, the pending mask, outstanding and err_unexp_rsp to 0;
- all val/ack outputs to 0.
REQ-021 Reset mid-transaction SHALL discard in-flight request and response state without further acks.

Structure
REQ-022 Shared package l15_xdcr_pkg SHALL hold:
- the FSM state encodings;
- L15_RET_INVAL = 4'b0011 and L15_RET_INT = 4'b0111.
REQ-023 Round-robin selection SHALL be a sub-module rr_arbiter (NUM_CH) with inputs req and ptr and outputs gnt_onehot, gnt_idx, any.

Verification
REQ-024 NUM_CH=2, both channels request at reset exit, L1.5 acks after 3 cycles:
- ch0 granted first; ch_req_ack[0] pulses;
- ch1 payload appears on xdcr_l15_payload 2 cycles after that ack, threadid=1.
REQ-025 Unicast response returntype 0000, threadid 1:
- xdcr_l15_req_ack pulses once;
- ch_rsp_val = 2'b10 the next cycle, held until ch_rsp_ack[1];
- outstanding[1] then clears.
REQ-026 Broadcast returntype 0011:
- ch_rsp_val = 2'b11;
- ch_rsp_ack[0] at +1, ch_rsp_ack[1] at +4;
- FSM idle one cycle after the second ack; outstanding unchanged.
REQ-027 ch0 outstanding with ch0 and ch1 both requesting -> only ch1 granted; ch0 granted after its response is acked.
REQ-028 NUM_CH=3, TID_W=2: response threadid 3 -> acked, no ch_rsp_val, err_unexp_rsp=1. Then assert rst_n low mid-lock -> all outputs 0 asynchronously, err cleared.

Source files
------------

// File: rtl/l15_xdcr_pkg.sv
// Shared encodings for the L1.5 transducer arbiter: FSM states and broadcast return types.
package l15_xdcr_pkg;

   typedef enum logic {REQ_IDLE, REQ_LOCK} req_state_e;
   typedef enum logic {RSP_IDLE, RSP_DELIVER} rsp_state_e;

   localparam logic [3:0] L15_RET_INVAL = 4'b0011;
   localparam logic [3:0] L15_RET_INT   = 4'b0111;

   function automatic logic is_bcast(input logic [3:0] rt);
      return (rt == L15_RET_INVAL) || (rt == L15_RET_INT);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester at or after ptr, wrapping modulo NUM_CH.
module rr_arbiter #(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned IDX_W  = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [IDX_W-1:0]  ptr,
   output logic [NUM_CH-1:0] gnt_onehot,
   output logic [IDX_W-1:0]  gnt_idx,
   output logic              any
);

   logic        found;
   int unsigned c;

   always_comb begin
      gnt_onehot = '0;
      gnt_idx    = '0;
      found      = 1'b0;
      c          = 0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         c = (32'(ptr) + k) % NUM_CH;
         if (!found && req[c]) begin
            found         = 1'b1;
            gnt_onehot[c] = 1'b1;
            gnt_idx       = IDX_W'(c);
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/l15_xdcr_arb.sv
// Arbitrates NUM_CH transducer channels onto one L1.5 request port and fans
// L1.5 responses back out, tracking one in-flight request per channel.
module l15_xdcr_arb
   import l15_xdcr_pkg::*;
#(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned TID_W  = 1,
   parameter int unsigned REQ_W  = 180,
   parameter int unsigned RSP_W  = 300
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH-1:0]       ch_req_val,
   input  logic [NUM_CH*REQ_W-1:0] ch_req_payload,
   output logic [NUM_CH-1:0]       ch_req_ack,
   output logic                    xdcr_l15_val,
   output logic [REQ_W-1:0]        xdcr_l15_payload,
   output logic [TID_W-1:0]        xdcr_l15_threadid,
   input  logic                    l15_xdcr_ack,
   input  logic                    l15_xdcr_val,
   input  logic [3:0]              l15_xdcr_returntype,
   input  logic [TID_W-1:0]        l15_xdcr_threadid,
   input  logic [RSP_W-1:0]        l15_xdcr_payload,
   output logic                    xdcr_l15_req_ack,
   output logic [NUM_CH-1:0]       ch_rsp_val,
   output logic [3:0]              ch_rsp_returntype,
   output logic [RSP_W-1:0]        ch_rsp_payload,
   input  logic [NUM_CH-1:0]       ch_rsp_ack,
   output logic [NUM_CH-1:0]       outstanding,
   output logic                    err_unexp_rsp
);

   localparam int unsigned IDX_W = $clog2(NUM_CH);

   if (NUM_CH < 2 || NUM_CH > 8 || NUM_CH > (1 << TID_W)) begin : g_param_check
      $error("l15_xdcr_arb: NUM_CH must be 2..8 and fit in TID_W");
   end

   // Request side
   req_state_e        req_state_q;
   logic [NUM_CH-1:0] owner_oh_q;
   logic [IDX_W-1:0]  owner_idx_q;
   logic [IDX_W-1:0]  rr_ptr_q;
   logic [NUM_CH-1:0] eligible;
   logic [NUM_CH-1:0] gnt_onehot;
   logic [IDX_W-1:0]  gnt_idx;
   logic              gnt_any;

   assign eligible   = ch_req_val & ~outstanding;
   assign ch_req_ack = (req_state_q == REQ_LOCK && l15_xdcr_ack) ? owner_oh_q : '0;

   rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_rr_arbiter (
      .req        (eligible),
      .ptr        (rr_ptr_q),
      .gnt_onehot (gnt_onehot),
      .gnt_idx    (gnt_idx),
      .any        (gnt_any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_state_q       <= REQ_IDLE;
         owner_oh_q        <= '0;
         owner_idx_q       <= '0;
         rr_ptr_q          <= '0;
         xdcr_l15_val      <= 1'b0;
         xdcr_l15_payload  <= '0;
         xdcr_l15_threadid <= '0;
      end else begin
         case (req_state_q)
            REQ_IDLE: begin
               if (gnt_any) begin
                  req_state_q       <= REQ_LOCK;
                  owner_oh_q        <= gnt_onehot;
                  owner_idx_q       <= gnt_idx;
                  xdcr_l15_val      <= 1'b1;
                  xdcr_l15_payload  <= ch_req_payload[gnt_idx*REQ_W +: REQ_W];
                  xdcr_l15_threadid <= TID_W'(gnt_idx);
               end
            end
            REQ_LOCK: begin
               if (l15_xdcr_ack) begin
                  req_state_q  <= REQ_IDLE;
                  xdcr_l15_val <= 1'b0;
                  rr_ptr_q     <= (owner_idx_q == IDX_W'(NUM_CH - 1)) ? '0 : owner_idx_q + 1'b1;
               end
            end
         endcase
      end
   end

   // Response side
   rsp_state_e        rsp_state_q;
   logic [NUM_CH-1:0] pending_q;
   logic [NUM_CH-1:0] pending_nxt;
   logic [NUM_CH-1:0] tid_hit;
   logic [NUM_CH-1:0] rsp_clr;
   logic              rsp_unicast_q;
   logic              in_bcast;
   logic              rsp_accept;

   always_comb begin
      tid_hit = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         tid_hit[i] = (l15_xdcr_threadid == TID_W'(i));
      end
   end

   assign in_bcast         = is_bcast(l15_xdcr_returntype);
   assign rsp_accept       = (rsp_state_q == RSP_IDLE) && l15_xdcr_val;
   assign xdcr_l15_req_ack = rsp_accept && rst_n;
   assign pending_nxt      = pending_q & ~ch_rsp_ack;
   assign ch_rsp_val       = pending_q;
   assign rsp_clr = (rsp_state_q == RSP_DELIVER && rsp_unicast_q) ? (pending_q & ch_rsp_ack) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_state_q       <= RSP_IDLE;
         pending_q         <= '0;
         rsp_unicast_q     <= 1'b0;
         ch_rsp_returntype <= '0;
         ch_rsp_payload    <= '0;
      end else begin
         case (rsp_state_q)
            RSP_IDLE: begin
               if (l15_xdcr_val) begin
                  rsp_state_q       <= RSP_DELIVER;
                  ch_rsp_returntype <= l15_xdcr_returntype;
                  ch_rsp_payload    <= l15_xdcr_payload;
                  rsp_unicast_q     <= !in_bcast;
                  // An out-of-range threadid yields an empty mask: the response is dropped.
                  pending_q         <= in_bcast ? '1 : tid_hit;
               end
            end
            RSP_DELIVER: begin
               pending_q <= pending_nxt;
               if (pending_nxt == '0) rsp_state_q <= RSP_IDLE;
            end
         endcase
      end
   end

   // A new grant's set wins over a same-cycle response clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding   <= '0;
         err_unexp_rsp <= 1'b0;
      end else begin
         outstanding <= (outstanding & ~rsp_clr) | ch_req_ack;
         if (rsp_accept && !in_bcast && ((tid_hit == '0) || ((tid_hit & ~outstanding) != '0))) begin
            err_unexp_rsp <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_l15_xdcr_arb.sv
// Scoreboard bench for l15_xdcr_arb: a 2-channel and a 3-channel instance.
module tb_l15_xdcr_arb;
   import l15_xdcr_pkg::*;

   localparam int REQ_W = 180;
   localparam int RSP_W = 300;

   typedef struct {
      logic [1:0]       tid;
      logic [REQ_W-1:0] pl;
   } req_exp_t;

   typedef struct {
      logic [2:0]       mask;
      logic [3:0]       rt;
      logic [RSP_W-1:0] pl;
   } rsp_exp_t;

   req_exp_t exp_req_q[$];
   rsp_exp_t exp_rsp_q[$];
   int checks = 0;
   int errors = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 2-channel instance
   logic               rst_n2;
   logic [1:0]         req_val2, req_ack2, rsp_val2, rsp_ack2, outst2;
   logic [2*REQ_W-1:0] req_pl2;
   logic               x_val2, l15_ack2, l15_val2, rq_ack2, err2;
   logic [REQ_W-1:0]   x_pl2;
   logic [0:0]         x_tid2, l15_tid2;
   logic [3:0]         l15_rt2, rsp_rt2;
   logic [RSP_W-1:0]   l15_pl2, rsp_pl2;

   // 3-channel instance
   logic               rst_n3;
   logic [2:0]         req_val3, req_ack3, rsp_val3, rsp_ack3, outst3;
   logic [3*REQ_W-1:0] req_pl3;
   logic               x_val3, l15_ack3, l15_val3, rq_ack3, err3;
   logic [REQ_W-1:0]   x_pl3;
   logic [1:0]         x_tid3, l15_tid3;
   logic [3:0]         l15_rt3, rsp_rt3;
   logic [RSP_W-1:0]   l15_pl3, rsp_pl3;

   l15_xdcr_arb dut2 (
      .clk (clk), .rst_n (rst_n2),
      .ch_req_val (req_val2), .ch_req_payload (req_pl2), .ch_req_ack (req_ack2),
      .xdcr_l15_val (x_val2), .xdcr_l15_payload (x_pl2), .xdcr_l15_threadid (x_tid2),
      .l15_xdcr_ack (l15_ack2), .l15_xdcr_val (l15_val2), .l15_xdcr_returntype (l15_rt2),
      .l15_xdcr_threadid (l15_tid2), .l15_xdcr_payload (l15_pl2), .xdcr_l15_req_ack (rq_ack2),
      .ch_rsp_val (rsp_val2), .ch_rsp_returntype (rsp_rt2), .ch_rsp_payload (rsp_pl2),
      .ch_rsp_ack (rsp_ack2), .outstanding (outst2), .err_unexp_rsp (err2)
   );

   l15_xdcr_arb #(.NUM_CH (3), .TID_W (2), .REQ_W (REQ_W), .RSP_W (RSP_W)) dut3 (
      .clk (clk), .rst_n (rst_n3),
      .ch_req_val (req_val3), .ch_req_payload (req_pl3), .ch_req_ack (req_ack3),
      .xdcr_l15_val (x_val3), .xdcr_l15_payload (x_pl3), .xdcr_l15_threadid (x_tid3),
      .l15_xdcr_ack (l15_ack3), .l15_xdcr_val (l15_val3), .l15_xdcr_returntype (l15_rt3),
      .l15_xdcr_threadid (l15_tid3), .l15_xdcr_payload (l15_pl3), .xdcr_l15_req_ack (rq_ack3),
      .ch_rsp_val (rsp_val3), .ch_rsp_returntype (rsp_rt3), .ch_rsp_payload (rsp_pl3),
      .ch_rsp_ack (rsp_ack3), .outstanding (outst3), .err_unexp_rsp (err3)
   );

   function automatic logic [REQ_W-1:0] rand_req();
      logic [191:0] w;
      for (int i = 0; i < 6; i++) w[i*32 +: 32] = $urandom;
      return w[REQ_W-1:0];
   endfunction

   function automatic logic [RSP_W-1:0] rand_rsp();
      logic [319:0] w;
      for (int i = 0; i < 10; i++) w[i*32 +: 32] = $urandom;
      return w[RSP_W-1:0];
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (2) tick();
      l15_val2 = 1'b1; l15_ack2 = 1'b1; req_val2 = 2'b11;
      l15_val3 = 1'b1; l15_ack3 = 1'b1; req_val3 = 3'b111;
      #1;
      checks++;
      if ({x_val2, rq_ack2, req_ack2, rsp_val2, outst2, err2} !== 9'b0)
         $display("FAIL reset2: got %b required 0",
                  {x_val2, rq_ack2, req_ack2, rsp_val2, outst2, err2});
      checks++;
      if ({x_val3, rq_ack3, req_ack3, rsp_val3, outst3, err3} !== 12'b0)
         $display("FAIL reset3: got %b required 0",
                  {x_val3, rq_ack3, req_ack3, rsp_val3, outst3, err3});
      if ({x_val2, rq_ack2, req_ack2, rsp_val2, outst2, err2} !== 9'b0) errors++;
      if ({x_val3, rq_ack3, req_ack3, rsp_val3, outst3, err3} !== 12'b0) errors++;
      l15_val2 = 1'b0; l15_ack2 = 1'b0; req_val2 = 2'b00;
      l15_val3 = 1'b0; l15_ack3 = 1'b0; req_val3 = 3'b000;
   endtask

   task automatic test_rr_grant();
      req_exp_t e;
      logic [REQ_W-1:0] p0, p1;
      p0 = rand_req(); p1 = rand_req();
      req_pl2 = {p1, p0}; req_val2 = 2'b11;
      exp_req_q.push_back(req_exp_t'{tid: 2'd0, pl: p0});
      exp_req_q.push_back(req_exp_t'{tid: 2'd1, pl: p1});
      tick(); rst_n2 = 1'b1;
      tick();
      e = exp_req_q.pop_front();
      checks++;
      if (x_val2 !== 1'b1 || x_tid2 !== e.tid[0] || x_pl2 !== e.pl) begin
         errors++;
         $display("FAIL first_grant: got val=%b tid=%h pl=%h required val=1 tid=%h pl=%h",
                  x_val2, x_tid2, x_pl2, e.tid[0], e.pl);
      end
      req_val2[0] = 1'b0;
      repeat (3) begin
         tick();
         checks++;
         if (x_val2 !== 1'b1 || x_tid2 !== e.tid[0] || x_pl2 !== e.pl) begin
            errors++;
            $display("FAIL lock_hold: got val=%b tid=%h pl=%h required val=1 tid=%h pl=%h",
                     x_val2, x_tid2, x_pl2, e.tid[0], e.pl);
         end
      end
      l15_ack2 = 1'b1; #1;
      checks++;
      if (req_ack2 !== 2'b01) begin
         errors++; $display("FAIL ack_ch0: got %b required 01", req_ack2);
      end
      tick(); l15_ack2 = 1'b0;
      checks++;
      if (x_val2 !== 1'b0 || outst2 !== 2'b01) begin
         errors++; $display("FAIL gap_cycle: got val=%b outst=%b required 0/01", x_val2, outst2);
      end
      tick();
      e = exp_req_q.pop_front();
      checks++;
      if (x_val2 !== 1'b1 || x_tid2 !== e.tid[0] || x_pl2 !== e.pl) begin
         errors++;
         $display("FAIL second_grant: got val=%b tid=%h pl=%h required val=1 tid=%h pl=%h",
                  x_val2, x_tid2, x_pl2, e.tid[0], e.pl);
      end
      l15_ack2 = 1'b1; #1;
      checks++;
      if (req_ack2 !== 2'b10) begin
         errors++; $display("FAIL ack_ch1: got %b required 10", req_ack2);
      end
      tick(); l15_ack2 = 1'b0; req_val2 = 2'b00;
      checks++;
      if (x_val2 !== 1'b0 || outst2 !== 2'b11) begin
         errors++; $display("FAIL both_outst: got val=%b outst=%b required 0/11", x_val2, outst2);
      end
   endtask

   task automatic test_unicast_rsp();
      rsp_exp_t r;
      logic [RSP_W-1:0] pl;
      pl = rand_rsp();
      l15_val2 = 1'b1; l15_rt2 = 4'b0000; l15_tid2 = 1'b1; l15_pl2 = pl;
      exp_rsp_q.push_back(rsp_exp_t'{mask: 3'b010, rt: 4'b0000, pl: pl});
      #1;
      checks++;
      if (rq_ack2 !== 1'b1) begin
         errors++; $display("FAIL uni_req_ack: got %b required 1", rq_ack2);
      end
      tick(); l15_val2 = 1'b0; l15_pl2 = rand_rsp(); #1;
      r = exp_rsp_q.pop_front();
      checks++;
      if (rsp_val2 !== r.mask[1:0] || rsp_rt2 !== r.rt || rsp_pl2 !== r.pl || rq_ack2 !== 1'b0) begin
         errors++;
         $display("FAIL uni_deliver: got val=%b rt=%h ack=%b pl=%h required val=%b rt=%h ack=0 pl=%h",
                  rsp_val2, rsp_rt2, rq_ack2, rsp_pl2, r.mask[1:0], r.rt, r.pl);
      end
      repeat (2) tick();
      checks++;
      if (rsp_val2 !== 2'b10) begin
         errors++; $display("FAIL uni_hold: got %b required 10", rsp_val2);
      end
      rsp_ack2 = 2'b10; tick(); rsp_ack2 = 2'b00;
      checks++;
      if (rsp_val2 !== 2'b00 || outst2 !== 2'b01 || err2 !== 1'b0) begin
         errors++;
         $display("FAIL uni_done: got val=%b outst=%b err=%b required 00/01/0", rsp_val2, outst2, err2);
      end
   endtask

   task automatic test_broadcast();
      rsp_exp_t r;
      logic [RSP_W-1:0] pl;
      pl = rand_rsp();
      l15_val2 = 1'b1; l15_rt2 = L15_RET_INVAL; l15_tid2 = 1'b0; l15_pl2 = pl;
      exp_rsp_q.push_back(rsp_exp_t'{mask: 3'b011, rt: 4'b0011, pl: pl});
      #1;
      checks++;
      if (rq_ack2 !== 1'b1) begin
         errors++; $display("FAIL bc_req_ack: got %b required 1", rq_ack2);
      end
      tick(); l15_val2 = 1'b0;
      r = exp_rsp_q.pop_front();
      checks++;
      if (rsp_val2 !== r.mask[1:0] || rsp_rt2 !== r.rt || rsp_pl2 !== r.pl) begin
         errors++;
         $display("FAIL bc_deliver: got val=%b rt=%h pl=%h required val=%b rt=%h pl=%h",
                  rsp_val2, rsp_rt2, rsp_pl2, r.mask[1:0], r.rt, r.pl);
      end
      rsp_ack2 = 2'b01; tick(); rsp_ack2 = 2'b00;
      checks++;
      if (rsp_val2 !== 2'b10) begin
         errors++; $display("FAIL bc_partial: got %b required 10", rsp_val2);
      end
      repeat (2) tick();
      checks++;
      if (rsp_val2 !== 2'b10) begin
         errors++; $display("FAIL bc_hold: got %b required 10", rsp_val2);
      end
      rsp_ack2 = 2'b10; tick(); rsp_ack2 = 2'b00;
      checks++;
      if (rsp_val2 !== 2'b00 || outst2 !== 2'b01) begin
         errors++; $display("FAIL bc_done: got val=%b outst=%b required 00/01", rsp_val2, outst2);
      end
      // Probe that the FSM is idle again, then withdraw the probe.
      l15_val2 = 1'b1; l15_rt2 = 4'b0000; #1;
      checks++;
      if (rq_ack2 !== 1'b1) begin
         errors++; $display("FAIL bc_idle: got req_ack=%b required 1", rq_ack2);
      end
      l15_val2 = 1'b0;
   endtask

   task automatic test_outstanding_block();
      req_exp_t e;
      rsp_exp_t r;
      logic [REQ_W-1:0] p0, p1;
      logic [RSP_W-1:0] pl;
      p0 = rand_req(); p1 = rand_req();
      req_pl2 = {p1, p0}; req_val2 = 2'b11;
      exp_req_q.push_back(req_exp_t'{tid: 2'd1, pl: p1});
      tick();
      e = exp_req_q.pop_front();
      checks++;
      if (x_val2 !== 1'b1 || x_tid2 !== e.tid[0] || x_pl2 !== e.pl) begin
         errors++;
         $display("FAIL block_grant_ch1: got val=%b tid=%h pl=%h required val=1 tid=%h pl=%h",
                  x_val2, x_tid2, x_pl2, e.tid[0], e.pl);
      end
      l15_ack2 = 1'b1; tick(); l15_ack2 = 1'b0; req_val2 = 2'b01;
      exp_req_q.push_back(req_exp_t'{tid: 2'd0, pl: p0});
      repeat (2) tick();
      checks++;
      if (x_val2 !== 1'b0 || outst2 !== 2'b11) begin
         errors++; $display("FAIL block_ch0: got val=%b outst=%b required 0/11", x_val2, outst2);
      end
      pl = rand_rsp();
      l15_val2 = 1'b1; l15_rt2 = 4'b0000; l15_tid2 = 1'b0; l15_pl2 = pl;
      exp_rsp_q.push_back(rsp_exp_t'{mask: 3'b001, rt: 4'b0000, pl: pl});
      tick(); l15_val2 = 1'b0;
      r = exp_rsp_q.pop_front();
      checks++;
      if (rsp_val2 !== r.mask[1:0] || rsp_pl2 !== r.pl) begin
         errors++;
         $display("FAIL block_rsp: got val=%b pl=%h required val=%b pl=%h",
                  rsp_val2, rsp_pl2, r.mask[1:0], r.pl);
      end
      rsp_ack2 = 2'b01; tick(); rsp_ack2 = 2'b00;
      checks++;
      if (x_val2 !== 1'b0 || outst2 !== 2'b10) begin
         errors++; $display("FAIL block_clear: got val=%b outst=%b required 0/10", x_val2, outst2);
      end
      tick();
      e = exp_req_q.pop_front();
      checks++;
      if (x_val2 !== 1'b1 || x_tid2 !== e.tid[0] || x_pl2 !== e.pl) begin
         errors++;
         $display("FAIL block_grant_ch0: got val=%b tid=%h pl=%h required val=1 tid=%h pl=%h",
                  x_val2, x_tid2, x_pl2, e.tid[0], e.pl);
      end
      l15_ack2 = 1'b1; tick(); l15_ack2 = 1'b0; req_val2 = 2'b00;
      checks++;
      if (outst2 !== 2'b11) begin
         errors++; $display("FAIL block_final_outst: got %b required 11", outst2);
      end
   endtask

   task automatic test_bad_tid_and_reset();
      req_exp_t e;
      rsp_exp_t r;
      logic [REQ_W-1:0] p;
      logic [RSP_W-1:0] pl;
      rst_n3 = 1'b1; tick();
      l15_val3 = 1'b1; l15_rt3 = 4'b0000; l15_tid3 = 2'd3; l15_pl3 = rand_rsp(); #1;
      checks++;
      if (rq_ack3 !== 1'b1) begin
         errors++; $display("FAIL bad_tid_ack: got %b required 1", rq_ack3);
      end
      tick(); l15_val3 = 1'b0;
      checks++;
      if (rsp_val3 !== 3'b000 || err3 !== 1'b1) begin
         errors++; $display("FAIL bad_tid_drop: got val=%b err=%b required 000/1", rsp_val3, err3);
      end
      tick();
      checks++;
      if (rsp_val3 !== 3'b000 || err3 !== 1'b1) begin
         errors++; $display("FAIL err_sticky: got val=%b err=%b required 000/1", rsp_val3, err3);
      end
      p = rand_req();
      req_pl3 = '0; req_pl3[REQ_W +: REQ_W] = p; req_val3 = 3'b010;
      exp_req_q.push_back(req_exp_t'{tid: 2'd1, pl: p});
      tick();
      e = exp_req_q.pop_front();
      checks++;
      if (x_val3 !== 1'b1 || x_tid3 !== e.tid || x_pl3 !== e.pl) begin
         errors++;
         $display("FAIL grant3: got val=%b tid=%h pl=%h required val=1 tid=%h pl=%h",
                  x_val3, x_tid3, x_pl3, e.tid, e.pl);
      end
      l15_ack3 = 1'b1; l15_val3 = 1'b1; l15_tid3 = 2'd1;
      #2 rst_n3 = 1'b0;
      #1;
      checks++;
      if ({x_val3, req_ack3, rq_ack3, rsp_val3, outst3, err3, x_tid3} !== 14'b0 || x_pl3 !== '0) begin
         errors++;
         $display("FAIL async_reset: got %b pl=%h required all 0",
                  {x_val3, req_ack3, rq_ack3, rsp_val3, outst3, err3, x_tid3}, x_pl3);
      end
      l15_ack3 = 1'b0; l15_val3 = 1'b0; req_val3 = 3'b000;
      tick(); rst_n3 = 1'b1;
      tick();
      pl = rand_rsp();
      l15_val3 = 1'b1; l15_rt3 = 4'b0000; l15_tid3 = 2'd2; l15_pl3 = pl;
      exp_rsp_q.push_back(rsp_exp_t'{mask: 3'b100, rt: 4'b0000, pl: pl});
      tick(); l15_val3 = 1'b0;
      r = exp_rsp_q.pop_front();
      checks++;
      if (rsp_val3 !== r.mask || rsp_rt3 !== r.rt || rsp_pl3 !== r.pl || err3 !== 1'b1) begin
         errors++;
         $display("FAIL unexp_deliver: got val=%b err=%b pl=%h required val=%b err=1 pl=%h",
                  rsp_val3, err3, rsp_pl3, r.mask, r.pl);
      end
      rsp_ack3 = 3'b100; tick(); rsp_ack3 = 3'b000;
      checks++;
      if (rsp_val3 !== 3'b000 || outst3 !== 3'b000) begin
         errors++; $display("FAIL unexp_done: got val=%b outst=%b required 000/000", rsp_val3, outst3);
      end
   endtask

   initial begin
      rst_n2 = 1'b0; req_val2 = '0; req_pl2 = '0; l15_ack2 = 1'b0; l15_val2 = 1'b0;
      l15_rt2 = '0; l15_tid2 = '0; l15_pl2 = '0; rsp_ack2 = '0;
      rst_n3 = 1'b0; req_val3 = '0; req_pl3 = '0; l15_ack3 = 1'b0; l15_val3 = 1'b0;
      l15_rt3 = '0; l15_tid3 = '0; l15_pl3 = '0; rsp_ack3 = '0;
      test_reset();
      test_rr_grant();
      test_unicast_rsp();
      test_broadcast();
      test_outstanding_block();
      test_bad_tid_and_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
